// File: rtl/bcd_to_excess3_seq.sv
// Serial packed-BCD to Excess-3 encoder: converts one digit per clock, LSB digit first.
// Optional macro BCD2XS3_ERRMASK_EN adds a per-digit invalid mask output (out_err_mask).
module bcd_to_excess3_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_xs3,
    output logic                  out_err
`ifdef BCD2XS3_ERRMASK_EN
    ,
    output logic [DIGITS-1:0]     out_err_mask
`endif
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_work;
    logic [4*DIGITS-1:0] r_result;
`ifdef BCD2XS3_ERRMASK_EN
    logic [DIGITS-1:0]   r_err_mask;
`else
    logic                r_err;
`endif

    logic [4*DIGITS-1:0] w_conv;
    logic [DIGITS-1:0]   w_bad;
    logic [DIGITS-1:0]   w_sel;
    logic                w_cur_bad;
    logic                w_accept;

    // Every digit is converted in parallel; r_idx selects which one is committed this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_d;
            assign w_d                = r_work[4*gi +: 4];
            assign w_bad[gi]          = (w_d > 4'd9);
            assign w_conv[4*gi +: 4]  = w_bad[gi] ? 4'd0 : (w_d + 4'd3);
            assign w_sel[gi]          = (r_idx == IW'(gi));
        end
    endgenerate

    assign w_cur_bad = |(w_bad & w_sel);
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);
    assign out_xs3   = r_result;
`ifdef BCD2XS3_ERRMASK_EN
    assign out_err_mask = r_err_mask;
    assign out_err      = |r_err_mask;
`else
    assign out_err      = r_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_work   <= '0;
            r_result <= '0;
`ifdef BCD2XS3_ERRMASK_EN
            r_err_mask <= '0;
`else
            r_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_work   <= in_bcd;
                        r_result <= '0;
                        r_idx    <= '0;
                        r_state  <= S_CONV;
`ifdef BCD2XS3_ERRMASK_EN
                        r_err_mask <= '0;
`else
                        r_err      <= 1'b0;
`endif
                    end
                end
                S_CONV: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (w_sel[i]) begin
                            r_result[4*i +: 4] <= w_conv[4*i +: 4];
                        end
                    end
`ifdef BCD2XS3_ERRMASK_EN
                    r_err_mask <= r_err_mask | (w_bad & w_sel);
`else
                    if (w_cur_bad) begin
                        r_err <= 1'b1;
                    end
`endif
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BCD2XS3_ERRMASK_EN
    logic w_unused_ok;
    assign w_unused_ok = w_cur_bad;
`endif

endmodule

// File: tb/tb_bcd_to_excess3_seq.sv
// Bench for bcd_to_excess3_seq: a DIGITS=4 instance for word traffic and a DIGITS=1 instance for the digit sweep.
module tb_bcd_to_excess3_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [15:0] in_bcd, out_xs3;
    logic [3:0]  out_err_mask;
    logic        in1_valid, in1_ready, out1_valid, out1_ready, out1_err;
    logic [3:0]  in1_bcd, out1_xs3;
    logic [0:0]  out1_err_mask;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bcd_to_excess3_seq #(.DIGITS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_xs3(out_xs3), .out_err(out_err)
`ifdef BCD2XS3_ERRMASK_EN
        , .out_err_mask(out_err_mask)
`endif
    );

    bcd_to_excess3_seq #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in1_valid), .in_ready(in1_ready), .in_bcd(in1_bcd),
        .out_valid(out1_valid), .out_ready(out1_ready),
        .out_xs3(out1_xs3), .out_err(out1_err)
`ifdef BCD2XS3_ERRMASK_EN
        , .out_err_mask(out1_err_mask)
`endif
    );

`ifndef BCD2XS3_ERRMASK_EN
    assign out_err_mask  = 4'b0;
    assign out1_err_mask = 1'b0;
`endif

    // Reference: each decimal digit maps to digit+3; anything above 9 maps to 0 and flags an error.
    function automatic logic [15:0] model_xs3(input logic [15:0] b);
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            int d = (b >> (4 * i)) & 15;
            if (d <= 9) r = r + ((d + 3) << (4 * i));
        end
        return 16'(r);
    endfunction

    function automatic logic [3:0] model_mask(input logic [15:0] b);
        logic [3:0] m = 4'b0;
        for (int i = 0; i < 4; i++) begin
            int d = (b >> (4 * i)) & 15;
            m[i] = (d > 9);
        end
        return m;
    endfunction

    // Drives one word through the 4-digit instance with out_ready=1 and reports what came out.
    task automatic do_word(input logic [15:0] bcd, output int lat, output logic [15:0] xs3,
                           output logic err, output logic [3:0] mask, output bit to);
        int n = 0;
        to = 0; lat = 0; xs3 = 'x; err = 'x; mask = 'x;
        @(negedge clk);
        out_ready = 1'b1; in_bcd = bcd; in_valid = 1'b1;
        while (!in_ready && n < 30) begin @(negedge clk); n++; end
        if (!in_ready) begin to = 1; in_valid = 1'b0; return; end
        @(posedge clk); #1;
        in_valid = 1'b0; in_bcd = 16'($urandom);
        while (lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        if (!out_valid) begin to = 1; return; end
        xs3 = out_xs3; err = out_err; mask = out_err_mask;
        $display("word %h -> xs3 %h err %b lat %0d", bcd, xs3, err, lat);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_bcd = '0;
        in1_valid = 1'b0; out1_ready = 1'b1; in1_bcd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_xs3 !== 16'h0) $display("FAIL reset_out_xs3: got %h want 0000", out_xs3); else n_pass++;
        n_total++; if (out_err !== 1'b0) $display("FAIL reset_out_err: got %b want 0", out_err); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_basic;
        int lat; logic [15:0] x; logic e; logic [3:0] m; bit to;
        do_word(16'h1234, lat, x, e, m, to);
        n_total++; if (to) $display("FAIL basic_timeout: got timeout want result"); else n_pass++;
        n_total++; if (lat !== 4) $display("FAIL basic_latency: got %0d want 4", lat); else n_pass++;
        n_total++; if (x !== 16'h4567) $display("FAIL basic_xs3: got %h want 4567", x); else n_pass++;
        n_total++; if (e !== 1'b0) $display("FAIL basic_err: got %b want 0", e); else n_pass++;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL basic_ready_after: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_patterns;
        logic [15:0] words [4] = '{16'h9900, 16'h0000, 16'h12A4, 16'h0001};
        int lat; logic [15:0] x; logic e; logic [3:0] m; bit to;
        for (int k = 0; k < 4; k++) begin
            do_word(words[k], lat, x, e, m, to);
            n_total++; if (to) $display("FAIL pattern_timeout %h: got timeout", words[k]); else n_pass++;
            n_total++; if (x !== model_xs3(words[k]))
                $display("FAIL pattern_xs3 %h: got %h want %h", words[k], x, model_xs3(words[k])); else n_pass++;
            n_total++; if (e !== (|model_mask(words[k])))
                $display("FAIL pattern_err %h: got %b want %b", words[k], e, |model_mask(words[k])); else n_pass++;
`ifdef BCD2XS3_ERRMASK_EN
            n_total++; if (m !== model_mask(words[k]))
                $display("FAIL pattern_mask %h: got %b want %b", words[k], m, model_mask(words[k])); else n_pass++;
`endif
        end
    endtask

    task automatic test_random;
        int lat; logic [15:0] x, w; logic e; logic [3:0] m; bit to;
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(0, 12));
            do_word(w, lat, x, e, m, to);
            n_total++; if (to || x !== model_xs3(w) || e !== (|model_mask(w)) || lat !== 4)
                $display("FAIL random %h: got xs3 %h err %b lat %0d want xs3 %h err %b lat 4",
                         w, x, e, lat, model_xs3(w), |model_mask(w)); else n_pass++;
`ifdef BCD2XS3_ERRMASK_EN
            n_total++; if (m !== model_mask(w))
                $display("FAIL random_mask %h: got %b want %b", w, m, model_mask(w)); else n_pass++;
`endif
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] w1 = 16'h3141, w2 = 16'h5926, held;
        int n = 0;
        @(negedge clk);
        out_ready = 1'b0; in_bcd = w1; in_valid = 1'b1;
        while (!in_ready && n < 30) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_bcd = w2;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 40);
        n_total++; if (!out_valid) $display("FAIL bp_timeout: got no out_valid"); else n_pass++;
        held = out_xs3;
        n_total++; if (held !== model_xs3(w1)) $display("FAIL bp_xs3: got %h want %h", held, model_xs3(w1)); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (out_valid !== 1'b1 || out_xs3 !== held || in_ready !== 1'b0)
                $display("FAIL bp_hold cycle %0d: got valid %b xs3 %h ready %b want 1 %h 0",
                         i, out_valid, out_xs3, in_ready, held); else n_pass++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: got valid %b ready %b want 0 1", out_valid, in_ready); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_second_accept: got ready %b want 0", in_ready); else n_pass++;
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        n_total++; if (out_xs3 !== model_xs3(w2) || !out_valid)
            $display("FAIL bp_second_xs3: got %h valid %b want %h", out_xs3, out_valid, model_xs3(w2)); else n_pass++;
        $display("backpressure words %h %h -> %h %h", w1, w2, held, out_xs3);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat; logic [15:0] x; logic e; logic [3:0] m; bit to;
        int n = 0; bit seen = 0;
        @(negedge clk);
        out_ready = 1'b1; in_bcd = 16'h1A11; in_valid = 1'b1;
        while (!in_ready && n < 30) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0 || out_xs3 !== 16'h0 || out_err !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL midreset_state: got valid %b xs3 %h err %b ready %b want 0 0000 0 1",
                     out_valid, out_xs3, out_err, in_ready); else n_pass++;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (out_valid) seen = 1; end
        n_total++; if (seen) $display("FAIL midreset_discard: got out_valid want none"); else n_pass++;
        do_word(16'h5678, lat, x, e, m, to);
        n_total++; if (to || x !== 16'h89AB || e !== 1'b0)
            $display("FAIL midreset_fresh: got %h err %b want 89AB 0", x, e); else n_pass++;
    endtask

    task automatic test_single_digit;
        int n;
        for (int v = 0; v < 16; v++) begin
            logic [3:0] want_x = (v <= 9) ? 4'(v + 3) : 4'h0;
            logic want_e = (v > 9);
            @(negedge clk);
            out1_ready = 1'b1; in1_bcd = 4'(v); in1_valid = 1'b1;
            n = 0;
            while (!in1_ready && n < 20) begin @(negedge clk); n++; end
            @(posedge clk); #1;
            in1_valid = 1'b0;
            @(negedge clk);
            n_total++; if (out1_valid !== 1'b0) $display("FAIL d1_early %0d: got valid %b want 0", v, out1_valid); else n_pass++;
            @(negedge clk);
            n_total++; if (out1_valid !== 1'b1 || out1_xs3 !== want_x || out1_err !== want_e)
                $display("FAIL d1_sweep %0d: got valid %b xs3 %h err %b want 1 %h %b",
                         v, out1_valid, out1_xs3, out1_err, want_x, want_e); else n_pass++;
`ifdef BCD2XS3_ERRMASK_EN
            n_total++; if (out1_err_mask !== want_e) $display("FAIL d1_mask %0d: got %b want %b", v, out1_err_mask, want_e); else n_pass++;
`endif
            $display("digit %0d -> xs3 %h err %b", v, out1_xs3, out1_err);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic;
        test_patterns;
        test_random;
        test_backpressure;
        test_reset_mid;
        test_single_digit;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
